// File: rtl/btb_update_ctrl_if.sv
`default_nettype none
// ============================================================================
//  Module   : btb_update_ctrl_if
//  Purpose  : Resolve-stage to BTB-update-controller offer/accept handshake.
//  Revision : 1.0  initial release
// ============================================================================
interface btb_update_ctrl_if;
    logic        res_valid;
    logic        res_ready;
    logic [15:0] res_pc;
    logic [15:0] res_target;
    logic        res_taken;
    logic        res_mispredict;

    modport master (
        output res_valid,
        output res_pc,
        output res_target,
        output res_taken,
        output res_mispredict,
        input  res_ready
    );

    modport slave (
        input  res_valid,
        input  res_pc,
        input  res_target,
        input  res_taken,
        input  res_mispredict,
        output res_ready
    );
endinterface
`default_nettype wire

// File: rtl/btb_update_ctrl.sv
`default_nettype none
// ============================================================================
//  Module   : btb_update_ctrl
//  Purpose  : Sweeps the BTB invalid after reset, then queues resolved
//             branches and replays them as BTB/counter updates; mispredicts
//             raise a one-cycle flush. Optional macro: BTB_INVALIDATE_EN.
//  Revision : 1.0  initial release
// ============================================================================
module btb_update_ctrl #(
    parameter int          FIFO_DEPTH   = 4,
    parameter logic [15:0] EMPTY_TARGET = 16'hFFFF
) (
    input  wire               clk,
    input  wire               reset,
    btb_update_ctrl_if.slave  res,
    output logic              flush,
    output logic [15:0]       redirect_pc,
    output logic              btb_we,
    output logic [7:0]        btb_index,
    output logic [7:0]        btb_tag,
    output logic [15:0]       btb_target,
    output logic              cnt_update,
    output logic              cnt_taken,
    output logic              fetch_stall,
    output logic [3:0]        fill
);

    localparam int         c_PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam logic [3:0] c_DEPTH = 4'(FIFO_DEPTH);

    typedef enum logic [0:0] {
        S_INIT = 1'b0,
        S_RUN  = 1'b1
    } state_t;

    state_t               r_state;
    state_t               w_state_nxt;
    logic [7:0]           r_sweep;
    logic [7:0]           w_sweep_nxt;

    logic [c_PTR_W-1:0]   r_wr_ptr;
    logic [c_PTR_W-1:0]   r_rd_ptr;
    logic [3:0]           r_fill;
    logic [15:0]          r_q_pc     [FIFO_DEPTH];
    logic [15:0]          r_q_target [FIFO_DEPTH];
    logic                 r_q_taken  [FIFO_DEPTH];

    logic [7:0]           r_idx_hold;
    logic [7:0]           r_tag_hold;
    logic [15:0]          r_tgt_hold;
    logic                 r_flush;
    logic [15:0]          r_redirect;

    logic                 w_ready;
    logic                 w_push;
    logic                 w_pop;
    logic                 w_init_wr;
    logic [15:0]          w_head_pc;
    logic [15:0]          w_head_target;
    logic                 w_head_taken;

    assign w_ready       = (r_state == S_RUN) && (r_fill < c_DEPTH);
    assign w_push        = res.res_valid && w_ready;
    assign w_pop         = (r_state == S_RUN) && (r_fill != 4'd0);
    // Reset gates the sweep strobe so no write escapes while reset is held.
    assign w_init_wr     = (r_state == S_INIT) && !reset;
    assign w_head_pc     = r_q_pc[r_rd_ptr];
    assign w_head_target = r_q_target[r_rd_ptr];
    assign w_head_taken  = r_q_taken[r_rd_ptr];

    assign res.res_ready = w_ready;
    assign fetch_stall   = (r_state == S_INIT);
    assign fill          = r_fill;
    assign flush         = r_flush;
    assign redirect_pc   = r_redirect;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= S_INIT;
            r_sweep <= 8'd0;
        end else begin
            r_state <= w_state_nxt;
            r_sweep <= w_sweep_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_sweep_nxt = r_sweep;
        case (r_state)
            S_INIT: begin
                w_sweep_nxt = r_sweep + 8'd1;
                if (r_sweep == 8'hFF) begin
                    w_state_nxt = S_RUN;
                end
            end
            S_RUN:   w_state_nxt = S_RUN;
            default: w_state_nxt = S_INIT;
        endcase
    end

    always_comb begin
        btb_we     = 1'b0;
        btb_index  = r_idx_hold;
        btb_tag    = r_tag_hold;
        btb_target = r_tgt_hold;
        cnt_update = 1'b0;
        cnt_taken  = 1'b0;
        if (w_init_wr) begin
            btb_we     = 1'b1;
            btb_index  = r_sweep;
            btb_tag    = 8'h00;
            btb_target = EMPTY_TARGET;
        end else if (w_pop) begin
            cnt_update = 1'b1;
            cnt_taken  = w_head_taken;
            if (w_head_taken) begin
                btb_we     = 1'b1;
                btb_index  = w_head_pc[7:0];
                btb_tag    = w_head_pc[15:8];
                btb_target = w_head_target;
            end
`ifdef BTB_INVALIDATE_EN
            else begin
                btb_we     = 1'b1;
                btb_index  = w_head_pc[7:0];
                btb_tag    = w_head_pc[15:8];
                btb_target = EMPTY_TARGET;
            end
`endif
        end
    end

    // BTB bus keeps its last written value between writes.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_idx_hold <= 8'd0;
            r_tag_hold <= 8'd0;
            r_tgt_hold <= EMPTY_TARGET;
        end else if (btb_we) begin
            r_idx_hold <= btb_index;
            r_tag_hold <= btb_tag;
            r_tgt_hold <= btb_target;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_fill   <= 4'd0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + 1'b1;
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + 1'b1;
            end
            case ({w_push, w_pop})
                2'b10:   r_fill <= r_fill + 4'd1;
                2'b01:   r_fill <= r_fill - 4'd1;
                default: r_fill <= r_fill;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (w_push) begin
            r_q_pc[r_wr_ptr]     <= res.res_pc;
            r_q_target[r_wr_ptr] <= res.res_target;
            r_q_taken[r_wr_ptr]  <= res.res_taken;
        end
    end

    // Flush is taken straight from the accepted offer, bypassing the queue.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_flush    <= 1'b0;
            r_redirect <= 16'd0;
        end else begin
            r_flush <= w_push && res.res_mispredict;
            if (w_push && res.res_mispredict) begin
                r_redirect <= res.res_taken ? res.res_target : (res.res_pc + 16'd1);
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_btb_update_ctrl.sv
`default_nettype none
// ============================================================================
//  Module   : tb_btb_update_ctrl
//  Purpose  : Vector table, reset sequences and randomized offers compared
//             against a queue-based reference model.
//  Revision : 1.0  initial release
// ============================================================================
module tb_btb_update_ctrl;

    localparam int          DEPTH = 4;
    localparam logic [15:0] EMPTY = 16'hFFFF;
`ifdef BTB_INVALIDATE_EN
    localparam logic        c_INV = 1'b1;
`else
    localparam logic        c_INV = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        flush, btb_we, cnt_update, cnt_taken, fetch_stall;
    logic [15:0] redirect_pc, btb_target;
    logic [7:0]  btb_index, btb_tag;
    logic [3:0]  fill;

    btb_update_ctrl_if rif();

    btb_update_ctrl #(.FIFO_DEPTH(DEPTH), .EMPTY_TARGET(EMPTY)) dut (
        .clk(clk), .reset(reset), .res(rif),
        .flush(flush), .redirect_pc(redirect_pc), .btb_we(btb_we),
        .btb_index(btb_index), .btb_tag(btb_tag), .btb_target(btb_target),
        .cnt_update(cnt_update), .cnt_taken(cnt_taken),
        .fetch_stall(fetch_stall), .fill(fill)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_err = 0;

    typedef struct {
        logic [15:0] pc;
        logic [15:0] target;
        logic        taken;
    } ent_t;

    // Reference model: state as plain variables, pending updates as a queue.
    bit          m_run;
    int          m_sweep;
    ent_t        m_q[$];
    logic        m_flush;
    logic [15:0] m_redir;

    typedef struct {
        logic [15:0] pc;
        logic [15:0] tgt;
        logic        taken;
        logic        misp;
        logic        exp_flush;
        logic [15:0] exp_redir;
        logic        exp_we;
        logic [15:0] exp_btb_tgt;
        logic        exp_ct;
    } vec_t;

    vec_t vecs[6];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_run   = 1'b0;
        m_sweep = 0;
        m_q.delete();
        m_flush = 1'b0;
        m_redir = 16'd0;
    endtask

    task automatic model_edge(input logic v, input logic [15:0] pc, input logic [15:0] tgt,
                              input logic tk, input logic mp);
        ent_t e;
        bit   acc;
        if (reset) return;
        if (!m_run) begin
            if (m_sweep == 255) m_run = 1'b1;
            else m_sweep++;
            m_flush = 1'b0;
        end else begin
            acc = v && (m_q.size() < DEPTH);
            if (m_q.size() > 0) m_q.delete(0);
            if (acc) begin
                e.pc = pc; e.target = tgt; e.taken = tk;
                m_q.push_back(e);
            end
            m_flush = acc && mp;
            if (m_flush) m_redir = tk ? tgt : 16'(pc + 16'd1);
        end
    endtask

    task automatic tick(input logic v, input logic [15:0] pc, input logic [15:0] tgt,
                        input logic tk, input logic mp);
        rif.res_valid      = v;
        rif.res_pc         = pc;
        rif.res_target     = tgt;
        rif.res_taken      = tk;
        rif.res_mispredict = mp;
        @(posedge clk);
        model_edge(v, pc, tgt, tk, mp);
        #1;
    endtask

    task automatic check_model();
        logic       e_we, e_cu, e_ct, e_ready, e_stall;
        logic [7:0] e_idx, e_tag;
        logic [15:0] e_tgt;
        e_we = 1'b0; e_cu = 1'b0; e_ct = 1'b0; e_idx = 8'd0; e_tag = 8'd0; e_tgt = EMPTY;
        if (!m_run) begin
            e_we = 1'b1; e_idx = 8'(m_sweep); e_stall = 1'b1; e_ready = 1'b0;
        end else begin
            e_stall = 1'b0;
            e_ready = (m_q.size() < DEPTH);
            if (m_q.size() > 0) begin
                e_cu  = 1'b1;
                e_ct  = m_q[0].taken;
                e_we  = m_q[0].taken || c_INV;
                e_idx = m_q[0].pc[7:0];
                e_tag = m_q[0].pc[15:8];
                e_tgt = m_q[0].taken ? m_q[0].target : EMPTY;
            end
        end
        check("btb_we", 32'(btb_we), 32'(e_we));
        if (e_we) begin
            check("btb_index", 32'(btb_index), 32'(e_idx));
            check("btb_tag", 32'(btb_tag), 32'(e_tag));
            check("btb_target", 32'(btb_target), 32'(e_tgt));
        end
        check("cnt_update", 32'(cnt_update), 32'(e_cu));
        if (e_cu) check("cnt_taken", 32'(cnt_taken), 32'(e_ct));
        check("flush", 32'(flush), 32'(m_flush));
        if (m_flush) check("redirect_pc", 32'(redirect_pc), 32'(m_redir));
        check("fetch_stall", 32'(fetch_stall), 32'(e_stall));
        check("res_ready", 32'(rif.res_ready), 32'(e_ready));
        check("fill", 32'(fill), 32'(m_q.size()));
    endtask

    task automatic check_reset_state(input string tag);
        check({tag, "_fill"}, 32'(fill), 32'd0);
        check({tag, "_btb_we"}, 32'(btb_we), 32'd0);
        check({tag, "_cnt_update"}, 32'(cnt_update), 32'd0);
        check({tag, "_cnt_taken"}, 32'(cnt_taken), 32'd0);
        check({tag, "_flush"}, 32'(flush), 32'd0);
        check({tag, "_redirect"}, 32'(redirect_pc), 32'd0);
        check({tag, "_index"}, 32'(btb_index), 32'd0);
        check({tag, "_tag"}, 32'(btb_tag), 32'd0);
        check({tag, "_target"}, 32'(btb_target), 32'(EMPTY));
        check({tag, "_ready"}, 32'(rif.res_ready), 32'd0);
        check({tag, "_stall"}, 32'(fetch_stall), 32'd1);
    endtask

    task automatic assert_reset(input string tag);
        rif.res_valid = 1'b0;
        reset = 1'b1;
        #1;
        model_reset();
        check_reset_state(tag);
        tick(1'b0, 16'd0, 16'd0, 1'b0, 1'b0);
        tick(1'b0, 16'd0, 16'd0, 1'b0, 1'b0);
        check_reset_state({tag, "_held"});
        reset = 1'b0;
        #1;
    endtask

    initial begin
        vecs[0] = '{16'h1234, 16'h1300, 1'b1, 1'b1, 1'b1, 16'h1300, 1'b1,  16'h1300, 1'b1};
        vecs[1] = '{16'h00FF, 16'h0200, 1'b0, 1'b1, 1'b1, 16'h0100, c_INV, 16'hFFFF, 1'b0};
        vecs[2] = '{16'hFFFF, 16'h0040, 1'b0, 1'b1, 1'b1, 16'h0000, c_INV, 16'hFFFF, 1'b0};
        vecs[3] = '{16'hABCD, 16'h1111, 1'b1, 1'b0, 1'b0, 16'h0000, 1'b1,  16'h1111, 1'b1};
        vecs[4] = '{16'h0042, 16'h0050, 1'b0, 1'b0, 1'b0, 16'h0000, c_INV, 16'hFFFF, 1'b0};
        vecs[5] = '{16'h8000, 16'h7FFE, 1'b1, 1'b1, 1'b1, 16'h7FFE, 1'b1,  16'h7FFE, 1'b1};

        rif.res_valid = 1'b0; rif.res_pc = 16'd0; rif.res_target = 16'd0;
        rif.res_taken = 1'b0; rif.res_mispredict = 1'b0;
        model_reset();
        @(posedge clk); @(posedge clk); #1;
        check_reset_state("por");
        reset = 1'b0;
        #1;

        // Interrupt the sweep at index 100; it must restart from 0.
        for (int i = 0; i < 100; i++) begin
            check_model();
            tick(1'b0, 16'd0, 16'd0, 1'b0, 1'b0);
        end
        check("sweep_at_100", 32'(btb_index), 32'd100);
        assert_reset("rst_init");

        for (int i = 0; i < 256; i++) begin
            check_model();
            tick(1'b0, 16'd0, 16'd0, 1'b0, 1'b0);
        end
        check_model();
        check("run_stall", 32'(fetch_stall), 32'd0);
        check("run_ready", 32'(rif.res_ready), 32'd1);

        for (int i = 0; i < 6; i++) begin
            tick(1'b1, vecs[i].pc, vecs[i].tgt, vecs[i].taken, vecs[i].misp);
            check($sformatf("v%0d_flush", i), 32'(flush), 32'(vecs[i].exp_flush));
            if (vecs[i].exp_flush)
                check($sformatf("v%0d_redirect", i), 32'(redirect_pc), 32'(vecs[i].exp_redir));
            check($sformatf("v%0d_we", i), 32'(btb_we), 32'(vecs[i].exp_we));
            if (vecs[i].exp_we) begin
                check($sformatf("v%0d_index", i), 32'(btb_index), 32'(vecs[i].pc[7:0]));
                check($sformatf("v%0d_tag", i), 32'(btb_tag), 32'(vecs[i].pc[15:8]));
                check($sformatf("v%0d_target", i), 32'(btb_target), 32'(vecs[i].exp_btb_tgt));
            end
            check($sformatf("v%0d_cnt_update", i), 32'(cnt_update), 32'd1);
            check($sformatf("v%0d_cnt_taken", i), 32'(cnt_taken), 32'(vecs[i].exp_ct));
            tick(1'b0, 16'd0, 16'd0, 1'b0, 1'b0);
            check($sformatf("v%0d_idle_we", i), 32'(btb_we), 32'd0);
            check($sformatf("v%0d_idle_cnt", i), 32'(cnt_update), 32'd0);
            check($sformatf("v%0d_idle_flush", i), 32'(flush), 32'd0);
            check($sformatf("v%0d_idle_fill", i), 32'(fill), 32'd0);
            if (vecs[i].exp_we)
                check($sformatf("v%0d_hold_index", i), 32'(btb_index), 32'(vecs[i].pc[7:0]));
        end

        // Random offers, including bursts of back-to-back valid cycles.
        for (int i = 0; i < 400; i++) begin
            logic        v;
            logic [15:0] pc;
            check_model();
            v  = (i >= 300) ? 1'b1 : ($urandom_range(0, 9) < 7);
            pc = ($urandom_range(0, 15) == 0) ? 16'hFFFF : 16'($urandom);
            tick(v, pc, 16'($urandom), 1'($urandom), 1'($urandom));
        end
        check_model();

        // Reset while an entry is queued: it must never reach the BTB.
        tick(1'b1, 16'h5A5A, 16'h2222, 1'b1, 1'b1);
        check("pre_rst_fill", 32'(fill), 32'd1);
        assert_reset("rst_run");
        for (int i = 0; i < 260; i++) begin
            check_model();
            tick(1'b0, 16'd0, 16'd0, 1'b0, 1'b0);
        end
        check_model();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
`default_nettype wire
